// File: rtl/timeshared_demux_deser.sv
// timeshared_demux_deser: recovers two lanes of WORD_W-bit words from a 2:1 interleaved bit stream
//   clk          rising-edge clock shared with the upstream multiplexer
//   rst          asynchronous active-low reset
//   din          interleaved serial bit, one slot per clock
//   sync         marks a slot carrying a lane2 bit (phase reference)
//   clr          synchronous drop-lock
//   lane1_word   recovered lane1 word, bit 0 = first received; lane1_valid one-cycle strobe
//   lane2_word   recovered lane2 word, bit 0 = first received; lane2_valid one-cycle strobe
//   locked       high while the slot phase is locked
//   sync_err     one-cycle pulse when sync lands on an expected lane1 slot
module timeshared_demux_deser #(
    parameter int WORD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              sync,
    input  logic              clr,
    output logic [WORD_W-1:0] lane1_word,
    output logic              lane1_valid,
    output logic [WORD_W-1:0] lane2_word,
    output logic              lane2_valid,
    output logic              locked,
    output logic              sync_err
);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t            state, state_nxt;
    logic              phase, phase_nxt;
    logic [CW-1:0]     cnt1, cnt1_nxt, cnt2, cnt2_nxt;
    logic [WORD_W-1:0] sr1, sr1_nxt, sr2, sr2_nxt;
    logic [WORD_W-1:0] word1_nxt, word2_nxt;
    logic              v1_nxt, v2_nxt, err_nxt, start;

    assign locked = state == LOCKED;
    // phase=1 means the next slot is expected on lane1; a sync there (or any sync while
    // unlocked) restarts alignment with this slot as lane2 bit 0
    assign start = sync && (state == UNLOCKED || phase);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt1_nxt  = cnt1;
        cnt2_nxt  = cnt2;
        sr1_nxt   = sr1;
        sr2_nxt   = sr2;
        word1_nxt = lane1_word;
        word2_nxt = lane2_word;
        v1_nxt    = 1'b0;
        v2_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (clr) begin
            state_nxt = UNLOCKED;
            phase_nxt = 1'b0;
            cnt1_nxt  = '0;
            cnt2_nxt  = '0;
        end else if (start) begin
            state_nxt = LOCKED;
            phase_nxt = 1'b1;
            err_nxt   = state == LOCKED;
            sr2_nxt   = {{(WORD_W-1){1'b0}}, din};
            cnt2_nxt  = CW'(1);
            cnt1_nxt  = '0;
        end else if (state == LOCKED && !phase) begin
            phase_nxt     = 1'b1;
            sr2_nxt[cnt2] = din;
            cnt2_nxt      = cnt2 == LAST ? '0 : cnt2 + CW'(1);
            v2_nxt        = cnt2 == LAST;
            word2_nxt     = cnt2 == LAST ? sr2_nxt : lane2_word;
        end else if (state == LOCKED) begin
            phase_nxt     = 1'b0;
            sr1_nxt[cnt1] = din;
            cnt1_nxt      = cnt1 == LAST ? '0 : cnt1 + CW'(1);
            v1_nxt        = cnt1 == LAST;
            word1_nxt     = cnt1 == LAST ? sr1_nxt : lane1_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= UNLOCKED;
            phase       <= 1'b0;
            cnt1        <= '0;
            cnt2        <= '0;
            sr1         <= '0;
            sr2         <= '0;
            lane1_word  <= '0;
            lane2_word  <= '0;
            lane1_valid <= 1'b0;
            lane2_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            cnt1        <= cnt1_nxt;
            cnt2        <= cnt2_nxt;
            sr1         <= sr1_nxt;
            sr2         <= sr2_nxt;
            lane1_word  <= word1_nxt;
            lane2_word  <= word2_nxt;
            lane1_valid <= v1_nxt;
            lane2_valid <= v2_nxt;
            sync_err    <= err_nxt;
        end
    end
endmodule

// File: tb/tb_timeshared_demux_deser.sv
// tb_timeshared_demux_deser: randomized bench for timeshared_demux_deser against a slot-level model
module tb_timeshared_demux_deser;
    localparam int W = 4;

    logic         clk, rst, din, sync, clr;
    logic [W-1:0] lane1_word, lane2_word;
    logic         lane1_valid, lane2_valid, locked, sync_err;

    timeshared_demux_deser #(.WORD_W(W)) dut (
        .clk(clk), .rst(rst), .din(din), .sync(sync), .clr(clr),
        .lane1_word(lane1_word), .lane1_valid(lane1_valid),
        .lane2_word(lane2_word), .lane2_valid(lane2_valid),
        .locked(locked), .sync_err(sync_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_v1 = 0, n_v2 = 0, n_err = 0;
    int last_v1 = -1, last_v2 = -1;
    bit track = 0, period_chk = 0;
    logic [W-1:0] exp1[$], exp2[$];

    // reference: slot index since last alignment decides the lane, bits collect in queues
    bit           m_locked;
    int           m_pos;
    logic         q1[$], q2[$];
    logic [W-1:0] m_w1, m_w2;
    logic         m_v1, m_v2, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_pos = 0; q1.delete(); q2.delete();
        m_w1 = '0; m_w2 = '0; m_v1 = 0; m_v2 = 0; m_err = 0;
    endtask

    task automatic model_step(input logic d, input logic s, input logic c);
        m_v1 = 0; m_v2 = 0; m_err = 0;
        if (c) begin
            m_locked = 0; q1.delete(); q2.delete();
        end else if (!m_locked) begin
            if (s) begin m_locked = 1; m_pos = 0; q1.delete(); q2.delete(); q2.push_back(d); end
        end else begin
            m_pos++;
            if (m_pos % 2 == 0) q2.push_back(d);
            else if (s) begin m_err = 1; m_pos = 0; q1.delete(); q2.delete(); q2.push_back(d); end
            else q1.push_back(d);
        end
        if (q2.size() == W) begin
            for (int i = 0; i < W; i++) m_w2[i] = q2[i];
            m_v2 = 1; q2.delete();
        end
        if (q1.size() == W) begin
            for (int i = 0; i < W; i++) m_w1[i] = q1[i];
            m_v1 = 1; q1.delete();
        end
    endtask

    task automatic cycle(input logic d, input logic s, input logic c);
        din = d; sync = s; clr = c;
        @(posedge clk);
        model_step(d, s, c);
        #1;
        cyc++;
        check("lane1_word", lane1_word, m_w1);
        check("lane2_word", lane2_word, m_w2);
        check("lane1_valid", lane1_valid, m_v1);
        check("lane2_valid", lane2_valid, m_v2);
        check("locked", locked, m_locked);
        check("sync_err", sync_err, m_err);
        if (lane1_valid && lane2_valid) check("both_valid", 1, 0);
        if (lane1_valid) begin
            n_v1++;
            if (period_chk && last_v1 >= 0) check("v1_period", cyc - last_v1, 2 * W);
            last_v1 = cyc;
            if (track) begin
                if (exp1.size() == 0) check("t6_extra1", 1, 0);
                else check("t6_w1", lane1_word, exp1.pop_front());
            end
        end
        if (lane2_valid) begin
            n_v2++;
            if (period_chk && last_v2 >= 0) check("v2_period", cyc - last_v2, 2 * W);
            last_v2 = cyc;
            if (track) begin
                if (exp2.size() == 0) check("t6_extra2", 1, 0);
                else check("t6_w2", lane2_word, exp2.pop_front());
            end
        end
        if (sync_err) n_err++;
    endtask

    // upstream 2:1 mux: lane2 bits on even slots, lane1 on odd, sync always on slot 0
    task automatic send_pair(input logic [W-1:0] w1, input logic [W-1:0] w2, input bit rsync);
        exp1.push_back(w1);
        exp2.push_back(w2);
        for (int k = 0; k < 2 * W; k++)
            cycle(k % 2 == 0 ? w2[k/2] : w1[k/2],
                  k == 0 || (rsync && k % 2 == 0 && $urandom_range(1, 0) == 1), 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a1, a2, b2;
        logic [9:0]   bits;
        rst = 0; din = 0; sync = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        rst = 1;

        // 1: async reset mid-stream
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'($urandom), 1'b0, 1'b0);
        check("t1_locked_pre", locked, 1);
        rst = 0;
        model_reset();
        #1;
        check("t1_w1", lane1_word, 0);
        check("t1_w2", lane2_word, 0);
        check("t1_locked", locked, 0);
        check("t1_v", {lane1_valid, lane2_valid, sync_err}, 0);
        #2 rst = 1;
        cycle(1'b1, 1'b0, 1'b0);
        check("t1_locked_post", locked, 0);

        // 2: basic word pair
        a2 = 4'b1101; a1 = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            cycle(k % 2 == 0 ? a2[k/2] : a1[k/2], k == 0, 1'b0);
            if (k == 6) begin
                check("t2_v2", lane2_valid, 1);
                check("t2_w2", lane2_word, 4'b1101);
            end
            if (k == 7) begin
                check("t2_v1", lane1_valid, 1);
                check("t2_w1", lane1_word, 4'b0110);
            end
        end

        // 3: five back-to-back pairs
        n_v1 = 0; n_v2 = 0; n_err = 0; last_v1 = -1; last_v2 = -1; period_chk = 1;
        for (int p = 0; p < 5; p++) send_pair(W'($urandom), W'($urandom), 1'b0);
        period_chk = 0;
        exp1.delete(); exp2.delete();
        check("t3_n_v1", n_v1, 5);
        check("t3_n_v2", n_v2, 5);
        check("t3_n_err", n_err, 0);

        // 4: sync on a lane1 slot realigns
        bits = 10'($urandom);
        n_v1 = 0; n_v2 = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(bits[k], k == 0 || k == 3, 1'b0);
            if (k == 3) begin
                check("t4_err", sync_err, 1);
                n_v1 = 0; n_v2 = 0;
            end
            if (k == 4) check("t4_err_off", sync_err, 0);
        end
        b2 = {bits[9], bits[7], bits[5], bits[3]};
        check("t4_v2", lane2_valid, 1);
        check("t4_w2", lane2_word, b2);
        check("t4_n_v1", n_v1, 0);
        check("t4_n_v2", n_v2, 1);

        // 5: unlocked ignores data, clr drops lock and words hold
        cycle(1'b0, 1'b0, 1'b1);
        n_v1 = 0; n_v2 = 0;
        for (int k = 0; k < 20; k++) cycle(1'(k % 2), 1'b0, 1'b0);
        check("t5_locked", locked, 0);
        check("t5_nv", n_v1 + n_v2, 0);
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'($urandom), 1'b0, 1'b0);
        check("t5_locked_on", locked, 1);
        cycle(1'b1, 1'b1, 1'b1);
        check("t5_clr_locked", locked, 0);
        check("t5_hold_w1", lane1_word, m_w1);
        check("t5_hold_w2", lane2_word, b2);

        // 6: random upstream traffic
        track = 1;
        for (int p = 0; p < 125; p++) send_pair(W'($urandom), W'($urandom), 1'b1);
        track = 0;
        check("t6_left1", exp1.size(), 0);
        check("t6_left2", exp2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
